// File: rtl/bus_arbiter_if.sv
// Bus arbitration signal bundle shared between the masters and the central arbiter.
// The master modport is the requesting side; the slave modport is the arbiter itself.
interface bus_arbiter_if #(
  parameter int N_MASTERS = 3
);
  logic [N_MASTERS-1:0] HREQ;
  logic [N_MASTERS-1:0] HLOCK;
  logic                 HREADY;
  logic [1:0]           HRESP;
  logic [N_MASTERS-1:0] HSPLIT;
  logic [N_MASTERS-1:0] HGRANT;
  logic [1:0]           HMASTER;
  logic                 HMASTLOCK;
  logic [N_MASTERS-1:0] SPLIT_MASK;
  logic                 BUS_BUSY;

  modport master (
    output HREQ, HLOCK, HREADY, HRESP, HSPLIT,
    input  HGRANT, HMASTER, HMASTLOCK, SPLIT_MASK, BUS_BUSY
  );

  modport slave (
    input  HREQ, HLOCK, HREADY, HRESP, HSPLIT,
    output HGRANT, HMASTER, HMASTLOCK, SPLIT_MASK, BUS_BUSY
  );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with lock hold, SPLIT parking and tenure pre-emption.
// Every output comes straight from a flop; re-arbitration happens on the releasing edge.
module bus_arbiter #(
  parameter int N_MASTERS  = 3,
  parameter int TENURE_MAX = 16
) (
  input  logic          CLK,
  input  logic          RST_N,
  bus_arbiter_if.slave  bus
);
  typedef enum logic {IDLE = 1'b0, OWN = 1'b1} state_t;

  localparam logic [7:0] TEN_LIM = (TENURE_MAX == 0) ? 8'd0 : 8'(TENURE_MAX - 1);
  localparam logic [N_MASTERS-1:0] ONE_HOT0 = {{(N_MASTERS-1){1'b0}}, 1'b1};

  // First set bit of el scanning from start upward, wrapping; returns {found, index}.
  function automatic logic [2:0] pick(input logic [N_MASTERS-1:0] el, input logic [1:0] start);
    logic [2:0] res;
    res = 3'b000;
    for (int k = N_MASTERS - 1; k >= 0; k--) begin
      if (el[(int'(start) + k) % N_MASTERS]) begin
        res = {1'b1, 2'((int'(start) + k) % N_MASTERS)};
      end
    end
    return res;
  endfunction

  state_t               state_q, state_d;
  logic [N_MASTERS-1:0] grant_q, grant_d;
  logic [N_MASTERS-1:0] mask_q, mask_d;
  logic [1:0]           hmaster_q, hmaster_d;
  logic [1:0]           ptr_q, ptr_d;
  logic [7:0]           ten_q, ten_d;
  logic                 mastlock_q, mastlock_d;
  logic                 busy_q, busy_d;

  logic [N_MASTERS-1:0] elig_s, own_bit_s, excl_s, cand_s;
  logic [2:0]           pick_s;
  logic                 own_s, split_ev_s, rel_a_s, rel_b_s, arb_s, own_lock_s;

  assign own_s      = (state_q == OWN);
  assign own_bit_s  = ONE_HOT0 << hmaster_q;
  assign own_lock_s = bus.HLOCK[hmaster_q];
  assign elig_s     = bus.HREQ & ~mask_q;
  assign split_ev_s = own_s && !bus.HREADY && (bus.HRESP == 2'b11);
  assign rel_a_s    = !bus.HREQ[hmaster_q] && !own_lock_s;
  assign rel_b_s    = (TENURE_MAX != 0) && (ten_q >= TEN_LIM) && !own_lock_s;
  // A pre-empted or split owner must not win the arbitration that removes it.
  assign excl_s     = (split_ev_s || (own_s && bus.HREADY && rel_b_s)) ? own_bit_s : '0;
  assign cand_s     = elig_s & ~excl_s;
  assign pick_s     = pick(cand_s, ptr_q);
  assign arb_s      = !own_s || split_ev_s || (bus.HREADY && (rel_a_s || rel_b_s));

  // Next-state computation for the arbitration FSM and its registered outputs.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    hmaster_d  = hmaster_q;
    ptr_d      = ptr_q;
    ten_d      = ten_q;
    mastlock_d = mastlock_q;
    // A set from a SPLIT response overrides a same-cycle release pulse.
    mask_d     = (mask_q & ~bus.HSPLIT) | (split_ev_s ? own_bit_s : '0);
    if (arb_s) begin
      if (pick_s[2]) begin
        state_d    = OWN;
        grant_d    = ONE_HOT0 << pick_s[1:0];
        hmaster_d  = pick_s[1:0];
        ten_d      = 8'd0;
        ptr_d      = (int'(pick_s[1:0]) == N_MASTERS - 1) ? 2'd0 : pick_s[1:0] + 2'd1;
        mastlock_d = bus.HLOCK[pick_s[1:0]];
      end else begin
        state_d    = IDLE;
        grant_d    = '0;
        ten_d      = 8'd0;
        mastlock_d = 1'b0;
      end
    end else begin
      mastlock_d = own_lock_s;
      if (!own_lock_s && |(elig_s & ~own_bit_s)) begin
        ten_d = (ten_q == 8'hFF) ? ten_q : ten_q + 8'd1;
      end else begin
        ten_d = 8'd0;
      end
    end
    busy_d = (state_d == OWN);
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      mask_q     <= '0;
      hmaster_q  <= 2'd0;
      ptr_q      <= 2'd0;
      ten_q      <= 8'd0;
      mastlock_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      mask_q     <= mask_d;
      hmaster_q  <= hmaster_d;
      ptr_q      <= ptr_d;
      ten_q      <= ten_d;
      mastlock_q <= mastlock_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.HGRANT     = grant_q;
  assign bus.HMASTER    = hmaster_q;
  assign bus.HMASTLOCK  = mastlock_q;
  assign bus.SPLIT_MASK = mask_q;
  assign bus.BUS_BUSY   = busy_q;
endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios plus randomized traffic against a rule-level model.
module tb_bus_arbiter;
  localparam int N    = 3;
  localparam int TMAX = 4;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  int   checks = 0;
  int   errors = 0;

  bus_arbiter_if #(.N_MASTERS(N)) bus ();
  bus_arbiter #(.N_MASTERS(N), .TENURE_MAX(TMAX)) dut (.CLK(CLK), .RST_N(RST_N), .bus(bus));

  always #5 CLK = ~CLK;

  // Reference model state: owner -1 means nobody granted.
  int         m_owner, m_hm, m_ptr, m_ten;
  logic       m_ml;
  logic [2:0] m_mask;

  task automatic drive(input logic [2:0] req, input logic [2:0] lock, input logic rdy,
                       input logic [1:0] resp, input logic [2:0] spl);
    bus.HREQ = req; bus.HLOCK = lock; bus.HREADY = rdy; bus.HRESP = resp; bus.HSPLIT = spl;
  endtask

  task automatic step(input logic [2:0] req, input logic [2:0] lock, input logic rdy,
                      input logic [1:0] resp, input logic [2:0] spl);
    @(negedge CLK);
    drive(req, lock, rdy, resp, spl);
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST_N = 1'b0;
    drive(3'b000, 3'b000, 1'b1, 2'b00, 3'b000);
    @(negedge CLK);
    RST_N = 1'b1;
    m_owner = -1; m_hm = 0; m_ptr = 0; m_ten = 0; m_ml = 1'b0; m_mask = 3'b000;
  endtask

  task automatic model_edge(input logic [2:0] req, input logic [2:0] lock, input logic rdy,
                            input logic [1:0] resp, input logic [2:0] spl);
    logic [2:0] nmask;
    int excl, w, idx;
    bit arb, spl_ev, others;
    spl_ev = (m_owner >= 0) && !rdy && (resp == 2'b11);
    nmask = m_mask & ~spl;
    if (spl_ev) nmask[m_owner] = 1'b1;
    arb = 0; excl = -1;
    if (m_owner < 0) arb = 1;
    else if (spl_ev) begin arb = 1; excl = m_owner; end
    else if (rdy && !lock[m_owner]) begin
      if (TMAX != 0 && m_ten >= TMAX - 1) begin arb = 1; excl = m_owner; end
      else if (!req[m_owner]) arb = 1;
    end
    if (arb) begin
      w = -1;
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (w < 0 && req[idx] && !m_mask[idx] && idx != excl) w = idx;
      end
      if (w >= 0) begin
        m_owner = w; m_hm = w; m_ten = 0; m_ptr = (w + 1) % N; m_ml = lock[w];
      end else begin
        m_owner = -1; m_ml = 1'b0;
      end
    end else begin
      m_ml = lock[m_owner];
      others = 0;
      for (int i = 0; i < N; i++) if (i != m_owner && req[i] && !m_mask[i]) others = 1;
      if (!lock[m_owner] && others) m_ten = (m_ten < 255) ? m_ten + 1 : 255;
      else m_ten = 0;
    end
    m_mask = nmask;
  endtask

  task automatic test_reset();
    @(negedge CLK);
    RST_N = 1'b0;
    drive(3'b111, 3'b000, 1'b1, 2'b00, 3'b000);
    #1;
    checks++;
    if ({bus.HGRANT, bus.HMASTER, bus.HMASTLOCK, bus.SPLIT_MASK, bus.BUS_BUSY} !== 10'b0) begin
      errors++;
      $display("FAIL reset_state got grant=%b hm=%0d ml=%b mask=%b busy=%b want all zero",
               bus.HGRANT, bus.HMASTER, bus.HMASTLOCK, bus.SPLIT_MASK, bus.BUS_BUSY);
    end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    step(3'b001, 3'b000, 1'b1, 2'b00, 3'b000);
    checks++;
    if (bus.HGRANT !== 3'b001 || bus.HMASTER !== 2'd0 || bus.BUS_BUSY !== 1'b1) begin
      errors++;
      $display("FAIL single_grant got grant=%b hm=%0d busy=%b want 001/0/1", bus.HGRANT, bus.HMASTER, bus.BUS_BUSY);
    end
    for (int i = 0; i < 3; i++) step(3'b001, 3'b000, 1'b1, 2'b00, 3'b000);
    checks++;
    if (bus.HGRANT !== 3'b001) begin
      errors++;
      $display("FAIL single_hold got grant=%b want 001", bus.HGRANT);
    end
    step(3'b000, 3'b000, 1'b1, 2'b00, 3'b000);
    checks++;
    if (bus.HGRANT !== 3'b000 || bus.BUS_BUSY !== 1'b0 || bus.HMASTER !== 2'd0) begin
      errors++;
      $display("FAIL single_release got grant=%b busy=%b hm=%0d want 000/0/0", bus.HGRANT, bus.BUS_BUSY, bus.HMASTER);
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] reqs [4];
    logic [2:0] want [4];
    reqs = '{3'b111, 3'b110, 3'b101, 3'b011};
    want = '{3'b001, 3'b010, 3'b100, 3'b001};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(reqs[i], 3'b000, 1'b1, 2'b00, 3'b000);
      checks++;
      if (bus.HGRANT !== want[i]) begin
        errors++;
        $display("FAIL round_robin_%0d got grant=%b want %b", i, bus.HGRANT, want[i]);
      end
    end
  endtask

  task automatic test_lock();
    int bad;
    do_reset();
    step(3'b010, 3'b010, 1'b1, 2'b00, 3'b000);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      step(3'b111, 3'b010, 1'b1, 2'b00, 3'b000);
      if (bus.HGRANT !== 3'b010 || bus.HMASTLOCK !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL lock_hold got %0d bad cycles (last grant=%b ml=%b) want 0", bad, bus.HGRANT, bus.HMASTLOCK);
    end
    step(3'b101, 3'b000, 1'b1, 2'b00, 3'b000);
    checks++;
    if (bus.HGRANT !== 3'b100 || bus.HMASTER !== 2'd2) begin
      errors++;
      $display("FAIL lock_release got grant=%b hm=%0d want 100/2", bus.HGRANT, bus.HMASTER);
    end
  endtask

  task automatic test_preempt();
    do_reset();
    step(3'b001, 3'b000, 1'b1, 2'b00, 3'b000);
    for (int i = 0; i < 3; i++) step(3'b101, 3'b000, 1'b1, 2'b00, 3'b000);
    checks++;
    if (bus.HGRANT !== 3'b001) begin
      errors++;
      $display("FAIL preempt_early got grant=%b want 001", bus.HGRANT);
    end
    step(3'b101, 3'b000, 1'b1, 2'b00, 3'b000);
    checks++;
    if (bus.HGRANT !== 3'b100 || bus.HMASTER !== 2'd2) begin
      errors++;
      $display("FAIL preempt_move got grant=%b hm=%0d want 100/2", bus.HGRANT, bus.HMASTER);
    end
    do_reset();
    step(3'b001, 3'b000, 1'b1, 2'b00, 3'b000);
    for (int i = 0; i < 3; i++) step(3'b101, 3'b000, 1'b1, 2'b00, 3'b000);
    step(3'b101, 3'b000, 1'b0, 2'b00, 3'b000);
    step(3'b101, 3'b000, 1'b0, 2'b00, 3'b000);
    checks++;
    if (bus.HGRANT !== 3'b001) begin
      errors++;
      $display("FAIL preempt_wait got grant=%b want 001", bus.HGRANT);
    end
    step(3'b101, 3'b000, 1'b1, 2'b00, 3'b000);
    checks++;
    if (bus.HGRANT !== 3'b100) begin
      errors++;
      $display("FAIL preempt_delayed got grant=%b want 100", bus.HGRANT);
    end
  endtask

  task automatic test_split();
    int bad;
    do_reset();
    step(3'b001, 3'b000, 1'b1, 2'b00, 3'b000);
    step(3'b011, 3'b000, 1'b0, 2'b11, 3'b000);
    checks++;
    if (bus.SPLIT_MASK !== 3'b001 || bus.HGRANT !== 3'b010 || bus.HMASTER !== 2'd1) begin
      errors++;
      $display("FAIL split_park got mask=%b grant=%b hm=%0d want 001/010/1", bus.SPLIT_MASK, bus.HGRANT, bus.HMASTER);
    end
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      step(3'b011, 3'b000, 1'b1, 2'b00, 3'b000);
      if (bus.HGRANT !== 3'b010) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL split_ignored got %0d bad cycles (grant=%b) want 0", bad, bus.HGRANT);
    end
    step(3'b011, 3'b000, 1'b1, 2'b00, 3'b001);
    checks++;
    if (bus.SPLIT_MASK !== 3'b000 || bus.HGRANT !== 3'b010) begin
      errors++;
      $display("FAIL split_unmask got mask=%b grant=%b want 000/010", bus.SPLIT_MASK, bus.HGRANT);
    end
    step(3'b001, 3'b000, 1'b1, 2'b00, 3'b000);
    checks++;
    if (bus.HGRANT !== 3'b001) begin
      errors++;
      $display("FAIL split_regrant got grant=%b want 001", bus.HGRANT);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    step(3'b010, 3'b000, 1'b1, 2'b00, 3'b000);
    step(3'b110, 3'b000, 1'b0, 2'b11, 3'b000);
    checks++;
    if (bus.HGRANT !== 3'b100 || bus.SPLIT_MASK !== 3'b010) begin
      errors++;
      $display("FAIL areset_setup got grant=%b mask=%b want 100/010", bus.HGRANT, bus.SPLIT_MASK);
    end
    #2;
    RST_N = 1'b0;
    drive(3'b000, 3'b000, 1'b1, 2'b00, 3'b000);
    #1;
    checks++;
    if ({bus.HGRANT, bus.HMASTER, bus.HMASTLOCK, bus.SPLIT_MASK, bus.BUS_BUSY} !== 10'b0) begin
      errors++;
      $display("FAIL areset_immediate got grant=%b hm=%0d ml=%b mask=%b busy=%b want all zero",
               bus.HGRANT, bus.HMASTER, bus.HMASTLOCK, bus.SPLIT_MASK, bus.BUS_BUSY);
    end
    @(negedge CLK);
    RST_N = 1'b1;
    step(3'b110, 3'b000, 1'b1, 2'b00, 3'b000);
    checks++;
    if (bus.HGRANT !== 3'b010 || bus.HMASTER !== 2'd1) begin
      errors++;
      $display("FAIL areset_first_grant got grant=%b hm=%0d want 010/1", bus.HGRANT, bus.HMASTER);
    end
  endtask

  task automatic test_random();
    logic [2:0] req, lock, spl, exp_grant;
    logic       rdy;
    logic [1:0] resp;
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        req[i]  = ($urandom_range(3, 0) != 0);
        lock[i] = req[i] && ($urandom_range(5, 0) == 0);
        spl[i]  = ($urandom_range(7, 0) == 0);
      end
      rdy  = ($urandom_range(3, 0) != 0);
      resp = ($urandom_range(5, 0) == 0) ? 2'b11 : 2'($urandom_range(2, 0));
      step(req, lock, rdy, resp, spl);
      model_edge(req, lock, rdy, resp, spl);
      exp_grant = (m_owner >= 0) ? (3'b001 << m_owner) : 3'b000;
      checks++;
      if (bus.HGRANT !== exp_grant || bus.HMASTER !== 2'(m_hm) || bus.HMASTLOCK !== m_ml ||
          bus.SPLIT_MASK !== m_mask || bus.BUS_BUSY !== (m_owner >= 0)) begin
        errors++;
        $display("FAIL random_cycle_%0d got grant=%b hm=%0d ml=%b mask=%b busy=%b want %b/%0d/%b/%b/%b",
                 c, bus.HGRANT, bus.HMASTER, bus.HMASTLOCK, bus.SPLIT_MASK, bus.BUS_BUSY,
                 exp_grant, m_hm, m_ml, m_mask, (m_owner >= 0));
      end
    end
  endtask

  initial begin
    drive(3'b000, 3'b000, 1'b1, 2'b00, 3'b000);
    test_reset();
    test_single();
    test_round_robin();
    test_lock();
    test_preempt();
    test_split();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
